link_channel_model: RTL

Multi-channel, credit-flow-controlled successor to the single-lane link delay model. It arbitrates CHANNELS independent senders onto one serial link with a DELAY-cycle forward pipeline and a DELAY-cycle credit-return pipeline, and can optionally inject beat errors. Formal harnesses and simulation benches use it between router ports to model wire latency, backpressure through credits, and lossy links.

---
 rtl/link_channel_model.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/link_channel_model.sv
// Credit-flow-controlled multi-channel link: round-robin arbitration onto one
// DELAY-stage forward pipe, DELAY-stage credit return. Option: LINK_MODEL_ERR_INJECT_EN.
module link_channel_model #(
  parameter int WIDTH    = 32,
  parameter int DELAY    = 2,
  parameter int CHANNELS = 2,
  parameter int CREDITS  = 4,
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int CNTW    = $clog2(CREDITS + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [CW-1:0]             out_ch,
  output logic [WIDTH-1:0]          out_data,
`ifdef LINK_MODEL_ERR_INJECT_EN
  output logic                      out_error,
  input  logic                      err_inject,
`endif
  input  logic [CHANNELS-1:0]       credit_ret,
  output logic                      credit_ovf
);

  localparam int L = DELAY - 1;
  localparam logic [CNTW:0] CRED_MAX = (CNTW + 1)'(CREDITS);

  logic                fwd_valid_q [DELAY];
  logic                fwd_valid_d [DELAY];
  logic                fwd_err_q   [DELAY];
  logic                fwd_err_d   [DELAY];
  logic [CW-1:0]       fwd_ch_q    [DELAY];
  logic [CW-1:0]       fwd_ch_d    [DELAY];
  logic [WIDTH-1:0]    fwd_data_q  [DELAY];
  logic [WIDTH-1:0]    fwd_data_d  [DELAY];
  logic [CHANNELS-1:0] ret_q       [DELAY];
  logic [CHANNELS-1:0] ret_d       [DELAY];
  logic [CNTW-1:0]     credit_q    [CHANNELS];
  logic [CNTW-1:0]     credit_d    [CHANNELS];
  logic [CW-1:0]       last_grant_q, last_grant_d;
  logic                credit_ovf_q, credit_ovf_d;

  logic [CHANNELS-1:0] eligible, ret_now, err_ret;
  logic                grant_vld, grant_err;
  logic [CW-1:0]       grant_ch;
  logic [WIDTH-1:0]    grant_data;

  // A credit arriving at the end of the return pipe is usable in the same cycle.
  assign ret_now = ret_q[L];

  always_comb begin
    eligible = '0;
    err_ret  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      eligible[c] = in_valid[c] && ((credit_q[c] != '0) || ret_now[c]);
      err_ret[c]  = fwd_valid_q[L] && fwd_err_q[L] && (fwd_ch_q[L] == CW'(c));
    end
  end

  always_comb begin
    in_ready   = '0;
    grant_vld  = 1'b0;
    grant_ch   = last_grant_q;
    grant_data = '0;
    for (int i = 1; i <= CHANNELS; i++) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (!grant_vld && eligible[c] && (c == (int'(last_grant_q) + i) % CHANNELS)) begin
          grant_vld   = 1'b1;
          in_ready[c] = 1'b1;
          grant_ch    = CW'(c);
          grant_data  = in_data[c*WIDTH +: WIDTH];
        end
      end
    end
  end

`ifdef LINK_MODEL_ERR_INJECT_EN
  assign grant_err = grant_vld & err_inject;
`else
  assign grant_err = 1'b0;
`endif

  assign last_grant_d = grant_vld ? grant_ch : last_grant_q;

  // Payload/channel only move with a valid beat so outputs hold when idle.
  always_comb begin
    for (int i = 0; i < DELAY; i++) begin
      fwd_valid_d[i] = fwd_valid_q[i];
      fwd_err_d[i]   = fwd_err_q[i];
      fwd_ch_d[i]    = fwd_ch_q[i];
      fwd_data_d[i]  = fwd_data_q[i];
    end
    fwd_valid_d[0] = grant_vld;
    fwd_err_d[0]   = grant_err;
    if (grant_vld) begin
      fwd_ch_d[0]   = grant_ch;
      fwd_data_d[0] = grant_data;
    end
    for (int i = 1; i < DELAY; i++) begin
      fwd_valid_d[i] = fwd_valid_q[i-1];
      fwd_err_d[i]   = fwd_err_q[i-1];
      if (fwd_valid_q[i-1]) begin
        fwd_ch_d[i]   = fwd_ch_q[i-1];
        fwd_data_d[i] = fwd_data_q[i-1];
      end
    end
  end

  always_comb begin
    ret_d[0] = credit_ret | err_ret;
    for (int i = 1; i < DELAY; i++) begin
      ret_d[i] = ret_q[i-1];
    end
  end

  always_comb begin
    logic [CNTW:0] sum;
    credit_ovf_d = credit_ovf_q;
    for (int c = 0; c < CHANNELS; c++) begin
      sum = {1'b0, credit_q[c]} + {{CNTW{1'b0}}, ret_now[c]} - {{CNTW{1'b0}}, in_ready[c]};
      if (sum > CRED_MAX) begin
        credit_d[c]  = CNTW'(CREDITS);
        credit_ovf_d = 1'b1;
      end else begin
        credit_d[c] = sum[CNTW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DELAY; i++) begin
        fwd_valid_q[i] <= 1'b0;
        fwd_err_q[i]   <= 1'b0;
        fwd_ch_q[i]    <= '0;
        fwd_data_q[i]  <= '0;
        ret_q[i]       <= '0;
      end
      for (int c = 0; c < CHANNELS; c++) begin
        credit_q[c] <= CNTW'(CREDITS);
      end
      last_grant_q <= CW'(CHANNELS - 1);
      credit_ovf_q <= 1'b0;
    end else begin
      for (int i = 0; i < DELAY; i++) begin
        fwd_valid_q[i] <= fwd_valid_d[i];
        fwd_err_q[i]   <= fwd_err_d[i];
        fwd_ch_q[i]    <= fwd_ch_d[i];
        fwd_data_q[i]  <= fwd_data_d[i];
        ret_q[i]       <= ret_d[i];
      end
      for (int c = 0; c < CHANNELS; c++) begin
        credit_q[c] <= credit_d[c];
      end
      last_grant_q <= last_grant_d;
      credit_ovf_q <= credit_ovf_d;
    end
  end

  assign out_valid  = fwd_valid_q[L] & ~fwd_err_q[L];
  assign out_ch     = fwd_ch_q[L];
  assign out_data   = fwd_data_q[L];
  assign credit_ovf = credit_ovf_q;
`ifdef LINK_MODEL_ERR_INJECT_EN
  assign out_error  = fwd_valid_q[L] & fwd_err_q[L];
`endif

endmodule
